// File: rtl/branch_pkg.sv
// Shared types and defaults for the ID-stage branch resolve unit.
// Optional statistics counters are enabled with BRANCH_STATS_EN.
package branch_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    BR_BEQ = 2'b00,
    BR_BNE = 2'b01,
    BR_J   = 2'b10,
    BR_JR  = 2'b11
  } br_type_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT     = 2'b01,
    ST_REDIRECT = 2'b10
  } br_state_e;

  // J carries its target in the instruction; everything else reads rs/rt.
  function automatic logic needs_operands(input logic [1:0] t);
    return t != BR_J;
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational taken/target evaluation for one branch in ID.
module branch_target_calc
  import branch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [1:0]        br_type,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic [ADDR_W-1:0] rs_data,
  input  logic [ADDR_W-1:0] rt_data,
  output logic              taken,
  output logic [ADDR_W-1:0] target
);

  logic              eq;
  logic [ADDR_W-1:0] rel_tgt;

  assign eq      = (rs_data == rt_data);
  // PC-relative target wraps naturally in ADDR_W bits
  assign rel_tgt = br_pc + ADDR_W'(1) + br_offset;

  // Select decision and target by branch kind
  always_comb begin
    taken  = 1'b0;
    target = rel_tgt;
    case (br_type_e'(br_type))
      BR_BEQ: taken = eq;
      BR_BNE: taken = !eq;
      BR_J: begin
        taken  = 1'b1;
        target = br_offset;
      end
      BR_JR: begin
        taken  = 1'b1;
        target = rs_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolve FSM: waits on operand hazards, resolves, and
// holds the PC redirect until the pipeline is unstalled.
// Define BRANCH_STATS_EN to build the taken/resolve statistics counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  input  logic [1:0]        br_type,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic [ADDR_W-1:0] rs_data,
  input  logic [ADDR_W-1:0] rt_data,
  input  logic              operands_ready,
  input  logic              stall,
  output logic              br_ready,
  output logic              hold,
  output logic              select,
  output logic [ADDR_W-1:0] jump_address,
  output logic              flush,
  output logic [CNT_W-1:0]  taken_count,
  output logic [CNT_W-1:0]  resolve_count
);

  br_state_e         state_q, state_d;
  logic              taken;
  logic [ADDR_W-1:0] target;
  logic              resolve;
  logic              ops_missing;

  branch_target_calc #(.ADDR_W(ADDR_W)) u_calc (
    .br_type   (br_type),
    .br_pc     (br_pc),
    .br_offset (br_offset),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .taken     (taken),
    .target    (target)
  );

  assign ops_missing = needs_operands(br_type) && !operands_ready;

  // Next state, accept and hold decisions
  always_comb begin
    state_d  = state_q;
    resolve  = 1'b0;
    br_ready = 1'b0;
    hold     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          if (ops_missing) begin
            hold = 1'b1;
            if (!stall) state_d = ST_WAIT;
          end else if (!stall) begin
            resolve = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Branch squashed by an older redirect: drop it silently
        if (!br_valid)           state_d = ST_IDLE;
        else if (ops_missing)    hold    = 1'b1;
        else if (!stall)         resolve = 1'b1;
      end
      ST_REDIRECT: begin
        // Instruction in ID is the wrong-path one being flushed
        if (!stall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (resolve) begin
      br_ready = 1'b1;
      state_d  = taken ? ST_REDIRECT : ST_IDLE;
    end
    if (reset) begin
      resolve  = 1'b0;
      br_ready = 1'b0;
      hold     = 1'b0;
    end
  end

  // State and redirect registers; redirect persists until PC can move
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      select       <= 1'b0;
      flush        <= 1'b0;
      jump_address <= '0;
    end else begin
      state_q <= state_d;
      if (resolve) begin
        select <= taken;
        flush  <= taken;
        if (taken) jump_address <= target;
      end else if (state_q == ST_REDIRECT && !stall) begin
        select <= 1'b0;
        flush  <= 1'b0;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_q, resolve_q;

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_q   <= '0;
      resolve_q <= '0;
    end else if (resolve) begin
      if (!(&resolve_q))         resolve_q <= resolve_q + CNT_W'(1);
      if (taken && !(&taken_q))  taken_q   <= taken_q + CNT_W'(1);
    end
  end

  assign taken_count   = taken_q;
  assign resolve_count = resolve_q;
`else
  assign taken_count   = '0;
  assign resolve_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a redirect-target scoreboard.
module tb_branch_resolve_unit;
  import branch_pkg::*;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       br_valid;
  logic [1:0] br_type;
  logic [7:0] br_pc, br_offset, rs_data, rt_data;
  logic       operands_ready, stall;
  logic       br_ready, hold, select, flush;
  logic [7:0] jump_address;
  logic [15:0] taken_count, resolve_count;

  int n_pass  = 0;
  int n_total = 0;
  int m_res   = 0;
  int m_tak   = 0;
  logic [7:0] exp_q[$];

  branch_resolve_unit dut (
    .clk            (clk),
    .reset          (reset),
    .br_valid       (br_valid),
    .br_type        (br_type),
    .br_pc          (br_pc),
    .br_offset      (br_offset),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .operands_ready (operands_ready),
    .stall          (stall),
    .br_ready       (br_ready),
    .hold           (hold),
    .select         (select),
    .jump_address   (jump_address),
    .flush          (flush),
    .taken_count    (taken_count),
    .resolve_count  (resolve_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_target(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      $error("FAIL %s: observed redirect to %0h expected no redirect", tag, jump_address);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {24'h0, jump_address}, {24'h0, e});
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_res"}, {16'h0, resolve_count}, STATS ? m_res : 0);
    chk({tag, "_tak"}, {16'h0, taken_count},   STATS ? m_tak : 0);
  endtask

  task automatic drive(input logic v, input logic [1:0] t, input logic [7:0] pc,
                       input logic [7:0] off, input logic [7:0] rs, input logic [7:0] rt,
                       input logic rdy, input logic st);
    br_valid = v; br_type = t; br_pc = pc; br_offset = off;
    rs_data = rs; rt_data = rt; operands_ready = rdy; stall = st;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, BR_BEQ, 8'h0, 8'h0, 8'h0, 8'h0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_select", select, 0);
    chk("rst_flush", flush, 0);
    chk("rst_jaddr", jump_address, 0);
    chk("rst_ready", br_ready, 0);
    chk("rst_hold", hold, 0);
    chk_counts("rst_cnt");

    // BEQ taken, no stall: 0x10 + 1 + 5 = 0x16
    drive(1, BR_BEQ, 8'h10, 8'h05, 8'h33, 8'h33, 1, 0);
    #1;
    chk("beq_ready", br_ready, 1);
    chk("beq_hold", hold, 0);
    exp_q.push_back(8'h16); m_res++; m_tak++;
    tick();
    br_valid = 0;
    #1;
    chk("beq_select", select, 1);
    chk("beq_flush", flush, 1);
    chk_target("beq_target");
    chk("beq_redir_ready", br_ready, 0);
    tick();
    chk("beq_select_clr", select, 0);
    chk("beq_flush_clr", flush, 0);

    // BNE not taken, accepted immediately after the redirect ends
    drive(1, BR_BNE, 8'h20, 8'h04, 8'h07, 8'h07, 1, 0);
    #1;
    chk("bne_ready", br_ready, 1);
    m_res++;
    tick();
    br_valid = 0;
    #1;
    chk("bne_select", select, 0);
    chk("bne_flush", flush, 0);

    // JR with a two-cycle load-use hazard
    drive(1, BR_JR, 8'h30, 8'h00, 8'h55, 8'h00, 0, 0);
    #1;
    chk("jr_hold0", hold, 1);
    chk("jr_ready0", br_ready, 0);
    tick();
    chk("jr_hold1", hold, 1);
    chk("jr_ready1", br_ready, 0);
    chk("jr_select_wait", select, 0);
    tick();
    rs_data = 8'hA0; operands_ready = 1;
    #1;
    chk("jr_hold2", hold, 0);
    chk("jr_ready2", br_ready, 1);
    exp_q.push_back(8'hA0); m_res++; m_tak++;
    tick();
    br_valid = 0;
    #1;
    chk("jr_select", select, 1);
    chk_target("jr_target");
    tick();
    chk("jr_select_clr", select, 0);

    // J to 0x40 (never waits), then stall for 3 cycles in REDIRECT
    drive(1, BR_J, 8'h50, 8'h40, 8'h00, 8'h00, 0, 0);
    #1;
    chk("j_ready", br_ready, 1);
    chk("j_hold", hold, 0);
    exp_q.push_back(8'h40); m_res++; m_tak++;
    tick();
    drive(1, BR_J, 8'h51, 8'h99, 8'h00, 8'h00, 1, 1);
    #1;
    chk("j_select0", select, 1);
    chk("j_flush0", flush, 1);
    chk_target("j_target");
    chk("j_ignore_ready0", br_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) stall = 0;
      #1;
      chk($sformatf("j_select_hold%0d", i), select, 1);
      chk($sformatf("j_flush_hold%0d", i), flush, 1);
      chk($sformatf("j_jaddr_hold%0d", i), jump_address, 8'h40);
      chk($sformatf("j_ignore_ready%0d", i), br_ready, 0);
    end
    tick();
    br_valid = 0;
    #1;
    chk("j_select_clr", select, 0);
    chk("j_flush_clr", flush, 0);
    chk_counts("mid_cnt");

    // Stall while IDLE: nothing accepted, hold tracks operands
    drive(1, BR_BEQ, 8'h60, 8'h02, 8'h01, 8'h02, 1, 1);
    #1;
    chk("st_ready", br_ready, 0);
    chk("st_hold_rdy", hold, 0);
    operands_ready = 0;
    #1;
    chk("st_hold_nrdy", hold, 1);
    tick();
    operands_ready = 1; stall = 0;
    #1;
    chk("st_accept", br_ready, 1);
    m_res++;
    tick();
    br_valid = 0;
    #1;
    chk("st_nt_select", select, 0);

    // WAIT then squash: returns to IDLE with no redirect
    drive(1, BR_BNE, 8'h70, 8'h01, 8'h01, 8'h02, 0, 0);
    #1;
    chk("sq_hold", hold, 1);
    tick();
    br_valid = 0;
    #1;
    chk("sq_hold_drop", hold, 0);
    chk("sq_ready_drop", br_ready, 0);
    tick();
    chk("sq_select", select, 0);

    // Reset while in REDIRECT drops the redirect
    drive(1, BR_J, 8'h80, 8'h77, 8'h00, 8'h00, 1, 0);
    #1;
    chk("rr_ready", br_ready, 1);
    exp_q.push_back(8'h77); m_res++; m_tak++;
    tick();
    stall = 1; br_valid = 0;
    #1;
    chk("rr_select", select, 1);
    chk_target("rr_target");
    chk_counts("pre_rst_cnt");
    reset = 1;
    tick();
    reset = 0; stall = 0;
    m_res = 0; m_tak = 0;
    #1;
    chk("rr_select_rst", select, 0);
    chk("rr_flush_rst", flush, 0);
    chk("rr_jaddr_rst", jump_address, 0);
    chk_counts("post_rst_cnt");

    // Target wrap: 0xFE + 1 + 3 = 0x02
    drive(1, BR_BEQ, 8'hFE, 8'h03, 8'h09, 8'h09, 1, 0);
    #1;
    chk("wrap_ready", br_ready, 1);
    exp_q.push_back(8'h02); m_res++; m_tak++;
    tick();
    br_valid = 0;
    #1;
    chk("wrap_select", select, 1);
    chk_target("wrap_target");
    chk_counts("wrap_cnt");
    tick();
    chk("wrap_select_clr", select, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
